// File: rtl/divider_pkg.sv
// Shared types and constants for the 2N-by-N restoring divider.
// State encoding, default width and counter sizing helper.
package divider_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DIV_DW = 32;

  function automatic int clog2(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << n) < v) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/divider_64by32_step.sv
// One restoring iteration: shift in the next dividend bit,
// subtract the divisor when it fits, emit the quotient bit.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] r,
  input  logic          q_msb,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] r_next,
  output logic          q_bit
);

  logic [DW:0] shifted;

  // the subtraction only needs its low DW bits: a kept
  // difference is always below the divisor
  always_comb begin
    shifted = {r, q_msb};
    q_bit   = (shifted >= {1'b0, divisor});
    r_next  = q_bit ? (shifted[DW-1:0] - divisor)
                    : shifted[DW-1:0];
  end

endmodule

// File: rtl/divider_64by32.sv
// Iterative 2*DW by DW unsigned divider, one quotient bit
// per clock, start/busy/valid_out handshake.
module divider_64by32
  import divider_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            valid_out,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int CW = clog2(DW);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] count;
  logic [DW-1:0] dvsr;
  logic [DW-1:0] r;
  logic [DW-1:0] q;
  logic [DW-1:0] lo_keep;
  logic [DW-1:0] r_nx;
  logic          q_bit;
  logic          err_z;
  logic          err_o;
  logic          last;

  div_step #(.DW(DW)) u_step (
    .r       (r),
    .q_msb   (q[DW-1]),
    .divisor (dvsr),
    .r_next  (r_nx),
    .q_bit   (q_bit)
  );

  assign last = (count == CW'(DW - 1));
  assign busy = (state == ST_BUSY);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // accept in IDLE, leave BUSY after the final step
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_BUSY;
      ST_BUSY: if (last)  state_nx = ST_IDLE;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      dvsr        <= '0;
      r           <= '0;
      q           <= '0;
      lo_keep     <= '0;
      err_z       <= 1'b0;
      err_o       <= 1'b0;
      valid_out   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            dvsr    <= divisor;
            r       <= dividend[2*DW-1:DW];
            q       <= dividend[DW-1:0];
            lo_keep <= dividend[DW-1:0];
            count   <= '0;
            err_z   <= (divisor == '0);
            err_o   <= (divisor != '0) &&
                       (dividend[2*DW-1:DW] >= divisor);
          end
        end
        ST_BUSY: begin
          r     <= r_nx;
          q     <= {q[DW-2:0], q_bit};
          count <= count + 1'b1;
          if (last) begin
            valid_out <= 1'b1;
            if (err_z) begin
              quotient    <= '1;
              remainder   <= lo_keep;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (err_o) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              quotient    <= {q[DW-2:0], q_bit};
              remainder   <= r_nx;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_64by32.sv
// Self-checking bench for divider_64by32 (DW=32):
// vector table, corner sequences and a random model check.
module tb_divider_64by32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        valid_out;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  divider_64by32 #(.DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .valid_out   (valid_out),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [63:0] dd;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h want=%h", name, got, exp);
  endtask

  function automatic logic [65:0] res();
    return {quotient, remainder, div_by_zero, overflow};
  endfunction

  // plain-arithmetic reference: 64-bit divide, then the
  // error rules for zero divisor and oversized quotient
  function automatic logic [65:0] model(input logic [63:0] dd,
                                        input logic [31:0] dv);
    logic [63:0] qq;
    logic [63:0] rr;
    if (dv == 0) return {32'hFFFFFFFF, dd[31:0], 2'b10};
    qq = dd / {32'b0, dv};
    rr = dd % {32'b0, dv};
    if (qq > 64'h00000000_FFFFFFFF)
      return {32'hFFFFFFFF, 32'h0, 2'b01};
    return {qq[31:0], rr[31:0], 2'b00};
  endfunction

  // called at posedge+1; returns at posedge+1 of the valid cycle
  task automatic run_op(input logic [63:0] dd,
                        input logic [31:0] dv,
                        output int edges,
                        output int bcnt,
                        output logic ok);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    bcnt  = busy ? 1 : 0;
    while (!valid_out && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy) bcnt++;
    end
    ok = valid_out;
  endtask

  initial begin
    int          edges;
    int          bcnt;
    int          vcnt;
    logic        ok;
    logic [63:0] dd;
    logic [31:0] dv;
    logic [65:0] exp;
    int          sel;

    vecs[0] = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFFFFFE_00000001, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'd0, 1'b0, 1'b0};
    vecs[2] = '{64'h00000001_00000000, 32'd2,
                32'h80000000, 32'd0, 1'b0, 1'b0};
    vecs[3] = '{64'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0};
    vecs[4] = '{64'h00000002_00000000, 32'd2,
                32'hFFFFFFFF, 32'd0, 1'b0, 1'b1};
    vecs[5] = '{64'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[6] = '{64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'd0, 1'b0, 1'b1};
    vecs[7] = '{64'h00000000_FFFFFFFF, 32'd1,
                32'hFFFFFFFF, 32'd0, 1'b0, 1'b0};
    vecs[8] = '{64'h7FFFFFFF_FFFFFFFF, 32'h80000000,
                32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0};
    vecs[9] = '{64'h12345678_9ABCDEF0, 32'd0,
                32'hFFFFFFFF, 32'h9ABCDEF0, 1'b1, 1'b0};

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, valid_out, res()}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // table vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, edges, bcnt, ok);
      check($sformatf("vec%0d_valid", i), ok, 1);
      check($sformatf("vec%0d_result", i), res(),
            {vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov});
      check($sformatf("vec%0d_latency", i), edges, 33);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 32);
      check($sformatf("vec%0d_busy_in_valid", i), busy, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse_len", i), valid_out, 0);
    end

    // ignored start while busy, then start in the valid cycle
    dividend = 64'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    repeat (10) begin
      @(posedge clk); #1;
      edges++;
    end
    dividend = 64'd50;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    edges++;
    start    = 1'b0;
    dividend = 64'hDEAD_BEEF_0000_1234;
    divisor  = 32'd0;
    while (!valid_out && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("b2b_first_valid", valid_out, 1);
    check("b2b_first_latency", edges, 33);
    check("b2b_first_result", res(), {32'd14, 32'd2, 2'b00});
    run_op(64'd50, 32'd3, edges, bcnt, ok);
    check("b2b_second_valid", ok, 1);
    check("b2b_second_latency", edges, 33);
    check("b2b_second_result", res(), {32'd16, 32'd2, 2'b00});
    vcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_out) vcnt++;
    end
    check("b2b_no_queued_start", vcnt, 0);
    check("b2b_result_held", res(), {32'd16, 32'd2, 2'b00});

    // asynchronous reset in the middle of an operation
    dividend = 64'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_outputs", {busy, valid_out, res()}, '0);
    #10 reset = 1'b0;
    vcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_out) vcnt++;
    end
    check("rst_no_valid", vcnt, 0);
    check("rst_outputs_stay_zero", res(), '0);
    run_op(64'd9, 32'd4, edges, bcnt, ok);
    check("rst_after_valid", ok, 1);
    check("rst_after_result", res(), {32'd2, 32'd1, 2'b00});
    check("rst_after_latency", edges, 33);

    // random operands against the reference model
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 7);
      dv  = $urandom;
      dd  = {$urandom, $urandom};
      if (sel == 0) dv = 0;
      else if (sel == 1) dv = 32'($urandom_range(1, 15));
      if (sel >= 3 && dv != 0) dd[63:32] = dd[63:32] % dv;
      run_op(dd, dv, edges, bcnt, ok);
      exp = model(dd, dv);
      check($sformatf("rand%0d_valid", n), ok, 1);
      check($sformatf("rand%0d_result dd=%h dv=%h", n, dd, dv),
            res(), exp);
      if (exp[1:0] == 2'b00)
        check($sformatf("rand%0d_identity", n),
              {32'b0, quotient} * {32'b0, dv} +
              {32'b0, remainder}, dd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
